// File: rtl/prog_timer_if.sv
// Control/status bundle for prog_timer: the master drives the level-sampled
// controls, the slave (the timer) returns registered status.
interface prog_timer_if #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [CNT_W-1:0] load;
  logic [PRE_W-1:0] prescale;
  logic             done;
  logic             busy;
  logic             paused;
  logic [CNT_W-1:0] remaining;
  logic [7:0]       done_cnt;

  modport master (
    output start, stop, pause, periodic, load, prescale,
    input  done, busy, paused, remaining, done_cnt
  );

  modport slave (
    input  start, stop, pause, periodic, load, prescale,
    output done, busy, paused, remaining, done_cnt
  );
endinterface

// File: rtl/prog_timer.sv
// Programmable down-counting timer with prescaler, one-shot/auto-reload modes,
// pause, cancel and an expiry counter.
module prog_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  prog_timer_if.slave bus,
  output logic [1:0]  state_dbg
);

  // Controls are levels sampled on every rising edge, no handshake: priority
  // is stop > start > pause > counting; all status outputs are registered.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] lat_l;
  logic [PRE_W-1:0] pcnt;
  logic [PRE_W-1:0] lat_p;
  logic             lat_mode;
  logic             done_r;
  logic [7:0]       dcnt;
  logic             advance;

  // A PAUSED edge that sees pause low already counts, so the number of frozen
  // edges equals the number of edges that sampled pause high.
  assign advance = !bus.stop && !bus.start && !bus.pause &&
                   (state == RUN || state == PAUSED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      lat_l    <= '0;
      pcnt     <= '0;
      lat_p    <= '0;
      lat_mode <= 1'b0;
      done_r   <= 1'b0;
      dcnt     <= 8'd0;
    end else begin
      done_r <= 1'b0;
      if (bus.stop) begin
        state <= IDLE;
        rem   <= '0;
        pcnt  <= '0;
      end else if (bus.start) begin
        lat_l    <= bus.load;
        lat_p    <= bus.prescale;
        lat_mode <= bus.periodic;
        pcnt     <= '0;
        if (bus.load == '0) begin
          done_r <= 1'b1;
          dcnt   <= 8'd1;
          rem    <= '0;
          state  <= IDLE;
        end else begin
          dcnt  <= 8'd0;
          rem   <= bus.load;
          state <= bus.pause ? PAUSED : RUN;
        end
      end else begin
        if (state == RUN && bus.pause) state <= PAUSED;
        if (state == PAUSED && !bus.pause) state <= RUN;
        if (advance) begin
          if (pcnt == lat_p) begin
            pcnt <= '0;
            if (rem > CNT_W'(1)) begin
              rem <= rem - CNT_W'(1);
            end else begin
              done_r <= 1'b1;
              dcnt   <= dcnt + 8'd1;
              if (lat_mode) begin
                rem <= lat_l;
              end else begin
                rem   <= '0;
                state <= IDLE;
              end
            end
          end else begin
            pcnt <= pcnt + PRE_W'(1);
          end
        end
      end
    end
  end

  assign bus.done      = done_r;
  assign bus.busy      = (state == RUN) || (state == PAUSED);
  assign bus.paused    = (state == PAUSED);
  assign bus.remaining = rem;
  assign bus.done_cnt  = dcnt;
  assign state_dbg     = state;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer: linear steps with hand-computed expectations
// checked by immediate assertions.
module tb_prog_timer;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  prog_timer_if #(.CNT_W(32), .PRE_W(16)) bus ();

  prog_timer #(.CNT_W(32), .PRE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic per, input logic [31:0] l, input logic [15:0] p);
    bus.start    = st;
    bus.stop     = sp;
    bus.pause    = pa;
    bus.periodic = per;
    bus.load     = l;
    bus.prescale = p;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    step();
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_paused", {31'd0, bus.paused}, 32'd0);
    chk("rst_remaining", bus.remaining, 32'd0);
    chk("rst_done_cnt", {24'd0, bus.done_cnt}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    // one-shot L=3 P=1, start on first edge out of reset
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 16'd1);
    step();
    chk("os_start_rem", bus.remaining, 32'd3);
    chk("os_start_state", {30'd0, state_dbg}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    chk("os_k1_rem", bus.remaining, 32'd3);
    step();
    chk("os_k2_rem", bus.remaining, 32'd2);
    step();
    step();
    chk("os_k4_rem", bus.remaining, 32'd1);
    step();
    chk("os_k5_done", {31'd0, bus.done}, 32'd0);
    chk("os_k5_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("os_k6_done", {31'd0, bus.done}, 32'd1);
    chk("os_k6_busy", {31'd0, bus.busy}, 32'd0);
    chk("os_k6_dcnt", {24'd0, bus.done_cnt}, 32'd1);
    chk("os_k6_rem", bus.remaining, 32'd0);
    step();
    chk("os_k7_done", {31'd0, bus.done}, 32'd0);

    // periodic L=4 P=0
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd4, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("per_done_e%0d", e), {31'd0, bus.done}, (e % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("per_rem_e%0d", e), bus.remaining, (e % 4 == 0) ? 32'd4 : 32'(4 - e % 4));
      chk($sformatf("per_dcnt_e%0d", e), {24'd0, bus.done_cnt}, 32'(e / 4));
      chk($sformatf("per_busy_e%0d", e), {31'd0, bus.busy}, 32'd1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    chk("per_stop_busy", {31'd0, bus.busy}, 32'd0);
    chk("per_stop_rem", bus.remaining, 32'd0);
    chk("per_stop_dcnt", {24'd0, bus.done_cnt}, 32'd3);

    // pause: L=5 P=0, pause high at edges k+2..k+4
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    chk("pa_k1_rem", bus.remaining, 32'd4);
    bus.pause = 1'b1;
    for (int e = 2; e <= 4; e++) begin
      step();
      chk($sformatf("pa_k%0d_paused", e), {31'd0, bus.paused}, 32'd1);
      chk($sformatf("pa_k%0d_rem", e), bus.remaining, 32'd4);
    end
    bus.pause = 1'b0;
    step();
    chk("pa_k5_paused", {31'd0, bus.paused}, 32'd0);
    chk("pa_k5_rem", bus.remaining, 32'd3);
    step();
    step();
    chk("pa_k7_done", {31'd0, bus.done}, 32'd0);
    step();
    chk("pa_k8_done", {31'd0, bus.done}, 32'd1);
    chk("pa_k8_busy", {31'd0, bus.busy}, 32'd0);

    // stop on the expiry edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    bus.stop = 1'b1;
    step();
    chk("sx_done", {31'd0, bus.done}, 32'd0);
    chk("sx_busy", {31'd0, bus.busy}, 32'd0);
    chk("sx_dcnt", {24'd0, bus.done_cnt}, 32'd0);
    bus.stop = 1'b0;
    step();
    chk("sx_after_done", {31'd0, bus.done}, 32'd0);

    // start on the expiry edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 16'd0);
    step();
    chk("stx_done", {31'd0, bus.done}, 32'd0);
    chk("stx_rem", bus.remaining, 32'd2);
    chk("stx_dcnt", {24'd0, bus.done_cnt}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    chk("stx_k1_done", {31'd0, bus.done}, 32'd0);
    step();
    chk("stx_k2_done", {31'd0, bus.done}, 32'd1);
    chk("stx_k2_dcnt", {24'd0, bus.done_cnt}, 32'd1);

    // L=0 start
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 16'd5);
    step();
    chk("l0_done", {31'd0, bus.done}, 32'd1);
    chk("l0_busy", {31'd0, bus.busy}, 32'd0);
    chk("l0_dcnt", {24'd0, bus.done_cnt}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    chk("l0_after_done", {31'd0, bus.done}, 32'd0);
    chk("l0_after_busy", {31'd0, bus.busy}, 32'd0);

    // start with pause high enters PAUSED; L=1 P=2
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 16'd2);
    step();
    chk("sp_paused", {31'd0, bus.paused}, 32'd1);
    chk("sp_state", {30'd0, state_dbg}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    step();
    step();
    chk("sp_e2_done", {31'd0, bus.done}, 32'd0);
    step();
    chk("sp_e3_done", {31'd0, bus.done}, 32'd1);

    // reset mid-count
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd100, 16'd3);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 10; i++) step();
    chk("mr_busy_pre", {31'd0, bus.busy}, 32'd1);
    chk("mr_rem_pre", bus.remaining, 32'd98);
    rst_n = 1'b0;
    step();
    chk("mr_done", {31'd0, bus.done}, 32'd0);
    chk("mr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_paused", {31'd0, bus.paused}, 32'd0);
    chk("mr_rem", bus.remaining, 32'd0);
    chk("mr_dcnt", {24'd0, bus.done_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("mr_after_done", {31'd0, bus.done}, 32'd0);
    chk("mr_after_busy", {31'd0, bus.busy}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter CNT_W, default 32, width of load value and remaining count.
REQ-002 Parameter PRE_W, default 16, width of prescale divider.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-006 start  input  1  level sampled each edge; high = load and (re)start.
REQ-007 stop  input  1  high = cancel, return to IDLE, no done.
REQ-008 pause  input  1  high = freeze counting while active.
REQ-009 periodic  input  1  mode, sampled with start: 0 one-shot, 1 auto-reload.
REQ-010 load  input  CNT_W  tick count L, sampled with start.
REQ-011 prescale  input  PRE_W  divider P, sampled with start; tick every P+1 clocks.
REQ-012 done  output  1  one-cycle registered pulse per expiry.
REQ-013 busy  output  1  high in RUN or PAUSED.
REQ-014 paused  output  1  high in PAUSED.
REQ-015 remaining  output  CNT_W  ticks left in current period (registered).
REQ-016 done_cnt  output  8  expiries since last start; wraps 255->0.

Function
REQ-017 States SHALL be IDLE, RUN, PAUSED; encoding is free.
REQ-018 Per-edge priority SHALL be: stop > start > pause > counting.
REQ-019 stop high: next state IDLE, remaining=0, prescale counter=0, done=0; latched L, P and mode held.
REQ-020 start high, stop low, L!=0, any state: latch L, P, mode; remaining=L; prescale counter=0; done_cnt=0; next state PAUSED if pause high, else RUN.
REQ-021 start high, L=0: done pulses one cycle; done_cnt=1; next state IDLE regardless of periodic.
REQ-022 RUN: prescale counter increments each edge; at count==P it wraps to 0 and a tick occurs; P=0 SHALL tick every edge.
REQ-023 On a tick with remaining>1: remaining decrements by 1.
REQ-024 On a tick with remaining==1: done=1 for exactly one cycle; done_cnt increments mod 256.
REQ-025 On expiry, one-shot mode: remaining=0, next state IDLE.
REQ-026 On expiry, periodic mode: remaining=latched L, prescale counter=0, stay RUN.
REQ-027 Timing: done SHALL be high in the cycle after edge k+L*(P+1), where edge k sampled start; periodic expiries SHALL follow every L*(P+1) cycles with no gap cycle.
REQ-028 RUN with pause high: next state PAUSED; counters frozen that edge.
REQ-029 PAUSED with pause low: next state RUN; counting resumes on the following edge; total active edges to expiry unchanged.
REQ-030 stop and expiry on the same edge: stop wins, no done, no done_cnt increment.
REQ-031 start and expiry on the same edge: restart per REQ-020; done suppressed.
REQ-032 start in IDLE with stop low and pause low SHALL enter RUN.
REQ-033 Arithmetic SHALL be unsigned; L*(P+1) is never formed as a product; no overflow path exists.

Reset
REQ-034 rst_n low at an edge, in any state including mid-count, SHALL force IDLE.
REQ-035 rst_n low at an edge SHALL clear done, busy, paused, remaining, done_cnt, prescale counter and the latched L, P and mode to 0.
REQ-036 The first edge with rst_n high SHALL accept start.

Verification
REQ-037 One-shot: L=3, P=1, periodic=0, start at edge k -> single done at cycle after edge k+6; busy falls with it; done_cnt=1.
REQ-038 Periodic: L=4, P=0, periodic=1 -> done after edges k+4, k+8, k+12; done_cnt 1,2,3; busy stays high.
REQ-039 Pause: L=5, P=0, pause high for 3 edges from edge k+2 -> done after edge k+8; paused high those 3 cycles.
REQ-040 Stop on expiry edge, and start on expiry edge with L=2 -> stop case: no done, IDLE; start case: no done, remaining=2, done 2 edges later.
REQ-041 L=0 start -> one done pulse, busy never high; rst_n low mid-count (L=100) -> all outputs 0 next cycle, no done.
